line_window_buffer: RTL and testbench
=====================================

// Module: line_window_buffer
// PURPOSE
//  Parametrised KH-row sliding-window buffer for the conv pipeline. Accepts one full feature-map row
//  (W pixels x K channels) per handshake, presents KH consecutive rows as one window to the downstream
//  conv block, and advances by STRIDE rows each time the conv block signals behind_conv_done.
//  Generalises the fixed 3-row buffer: window height, vertical stride, frame end handling, input backpressure.
// PARAMETERS
//  DATA_BITS  8   bits per pixel per channel
//  W          24  pixels per row
//  K          6   channels per pixel
//  H          6   rows per frame (H >= KH)
//  KH         3   window height in rows (>= 2)
//  STRIDE     1   rows discarded per window advance (1 <= STRIDE <= KH)
//  ROW_W = W*DATA_BITS*K (localparam)
// PORTS
//  clk               in   1           clock, all logic on rising edge
//  reset             in   1           synchronous, active-high reset
//  input_data        in   ROW_W       one full row
//  valid_i           in   1           input_data valid; held with data until accepted
//  ready_o           out  1           row accepted on clk edge when valid_i && ready_o
//  window_o          out  KH*ROW_W    rows; slice [0 +: ROW_W] = oldest (top) row
//  valid_o           out  1           window_o complete and stable
//  behind_conv_done  in   1           1-cycle pulse: conv done with current window
//  window_idx_o      out  $clog2(H+1) index of current window within frame, from 0
//  frame_done_o      out  1           1-cycle pulse: frame fully consumed
// BEHAVIOUR
//  Reset: window_o=0, valid_o=0, ready_o=1, window_idx_o=0, frame_done_o=0; row count, rows_in=0, state FILL.
//  Reset mid-operation discards all held rows and counters; no frame_done_o pulse.
//  Storage r[0..KH-1]; cnt = rows held; rows_in = rows accepted this frame.
//  FILL: ready_o=1. Accept -> r[cnt]<=input_data, cnt++, rows_in++. When cnt reaches KH -> HOLD;
//        valid_o=1 the cycle after the KH-th accept (1-cycle latency), ready_o=0 same cycle.
//  HOLD: ready_o=0, valid_o=1, window_o stable; valid_i ignored (upstream holds).
//        behind_conv_done at edge t -> at t+1: valid_o=0, r[i]<=r[i+STRIDE], cnt-=STRIDE, window_idx_o++.
//        Then if next top row + KH <= H (padded H with ZERO_PAD_EN) -> FILL;
//        else if rows_in==H -> frame_done_o=1 at t+1, all counters cleared, FILL;
//        else -> DRAIN.
//  DRAIN: ready_o=1, accepted rows discarded, rows_in++; on accept of row H-1 -> frame_done_o=1 next
//        cycle, counters cleared, FILL.
//  behind_conv_done outside HOLD ignored. valid_i && !ready_o: no accept, no state change.
//  Frame yields floor((H-KH)/STRIDE)+1 windows; window_idx_o wraps to 0 with frame_done_o.
//  Vacated rows r[cnt..KH-1] keep stale data; only valid_o qualifies window_o.
// CONFIGURATION
//  ZERO_PAD_EN defined: vertical zero padding, P=(KH-1)/2 rows top and bottom. Frame start preloads
//   r[0..P-1]=0, cnt=P. When rows_in==H and a window still needs rows, zero rows are inserted
//   internally (one per cycle, ready_o=0). Windows = floor((H+2P-KH)/STRIDE)+1; DRAIN applies to padded height.
//  ZERO_PAD_EN undefined: no padding, behaviour as above; no preload logic synthesised.
// TESTING  (DATA_BITS=8,W=24,K=6,H=6,KH=3; rows A..F = {288{4'hA}}..{288{4'hF}})
//  1 Reset asserted 2 cycles -> valid_o=0, ready_o=1, window_o=0, window_idx_o=0, frame_done_o=0.
//  2 STRIDE=1, rows A..F, done pulse per window -> windows (A,B,C),(B,C,D),(C,D,E),(D,E,F);
//    window_idx_o 0..3; frame_done_o pulses once, cycle after 4th done; valid_o 1 cycle after 3rd accept.
//  3 valid_i held with D while HOLD on (A,B,C) for 10 cycles -> ready_o=0, window_o unchanged;
//    D accepted the cycle after done; next window (B,C,D).
//  4 STRIDE=2 -> windows (A,B,C),(C,D,E); after 2nd done DRAIN, F accepted and dropped, frame_done_o next cycle.
//  5 Reset after A,B accepted, then C,D,E -> first window (C,D,E), window_idx_o=0.
//  6 ZERO_PAD_EN, STRIDE=1 -> 6 windows: (0,A,B) first, (E,F,0) last; frame_done_o after 6th done.

Source files
------------

// File: rtl/line_window_buffer_if.sv
// Row-in / window-out handshake bundle for line_window_buffer.
// The slave modport is the buffer side; the master modport is the producer/conv side.
interface line_window_buffer_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned W         = 24,
  parameter int unsigned K         = 6,
  parameter int unsigned H         = 6,
  parameter int unsigned KH        = 3
);
  localparam int unsigned ROW_W = W * DATA_BITS * K;
  localparam int unsigned IdxW  = $clog2(H + 1);

  logic [ROW_W-1:0]    input_data;
  logic                valid_i;
  logic                ready_o;
  logic [KH*ROW_W-1:0] window_o;
  logic                valid_o;
  logic                behind_conv_done;
  logic [IdxW-1:0]     window_idx_o;
  logic                frame_done_o;

  modport master (
    output input_data, valid_i, behind_conv_done,
    input  ready_o, window_o, valid_o, window_idx_o, frame_done_o
  );

  modport slave (
    input  input_data, valid_i, behind_conv_done,
    output ready_o, window_o, valid_o, window_idx_o, frame_done_o
  );
endinterface

// File: rtl/line_window_buffer.sv
// KH-row sliding window over a frame of H rows, advancing STRIDE rows per conv-done pulse.
// Optional vertical zero padding is enabled with `define ZERO_PAD_EN.
module line_window_buffer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned W         = 24,
  parameter int unsigned K         = 6,
  parameter int unsigned H         = 6,
  parameter int unsigned KH        = 3,
  parameter int unsigned STRIDE    = 1
) (
  input logic                 clk,
  input logic                 reset,
  line_window_buffer_if.slave lwb_io
);
  localparam int unsigned ROW_W = W * DATA_BITS * K;
`ifdef ZERO_PAD_EN
  localparam int unsigned P = (KH - 1) / 2;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned HP    = H + 2 * P;
  localparam int unsigned CntW  = $clog2(KH + 1);
  localparam int unsigned RowsW = $clog2(H + 1);
  localparam int unsigned TopW  = $clog2(HP + 1);
  localparam int unsigned IdxW  = $clog2(H + 1);

  typedef enum logic [1:0] {StFill, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] r_q [KH];
  logic [ROW_W-1:0] r_d [KH];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RowsW-1:0] rows_in_q, rows_in_d;
  logic [TopW-1:0]  top_q, top_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             fd_q, fd_d;

  logic                ready;
  logic                accept;
  logic                pad_ins;
  logic                clr;
  logic [KH*ROW_W-1:0] win;

`ifdef ZERO_PAD_EN
  // All real rows are in but the window is short: feed bottom padding internally.
  assign pad_ins = (state_q == StFill) && (rows_in_q == RowsW'(H));
`else
  assign pad_ins = 1'b0;
`endif

  assign ready  = ((state_q == StFill) && !pad_ins) || (state_q == StDrain);
  assign accept = lwb_io.valid_i && ready;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    rows_in_d = rows_in_q;
    top_d     = top_q;
    idx_d     = idx_q;
    fd_d      = 1'b0;
    clr       = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept || pad_ins) begin
          for (int i = 0; i < int'(KH); i++) begin
            if (i == int'(cnt_q)) r_d[i] = accept ? lwb_io.input_data : '0;
          end
          cnt_d = cnt_q + CntW'(1);
          if (accept) rows_in_d = rows_in_q + RowsW'(1);
          if (cnt_q == CntW'(KH - 1)) state_d = StHold;
        end
      end
      StHold: begin
        if (lwb_io.behind_conv_done) begin
          // Shift up by STRIDE; the vacated tail rows keep stale data.
          for (int i = 0; i < int'(KH); i++) begin
            if (i + int'(STRIDE) < int'(KH)) r_d[i] = r_q[i+int'(STRIDE)];
          end
          cnt_d = cnt_q - CntW'(STRIDE);
          idx_d = idx_q + IdxW'(1);
          top_d = top_q + TopW'(STRIDE);
          if (int'(top_q) + int'(STRIDE) + int'(KH) <= int'(HP)) begin
            state_d = StFill;
          end else if (rows_in_q == RowsW'(H)) begin
            clr = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept) begin
          rows_in_d = rows_in_q + RowsW'(1);
          if (rows_in_q == RowsW'(H - 1)) clr = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase

    if (clr) begin
      state_d   = StFill;
      cnt_d     = CntW'(P);
      rows_in_d = '0;
      top_d     = '0;
      idx_d     = '0;
      fd_d      = 1'b1;
      for (int i = 0; i < int'(P); i++) r_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFill;
      cnt_q     <= CntW'(P);
      rows_in_q <= '0;
      top_q     <= '0;
      idx_q     <= '0;
      fd_q      <= 1'b0;
      for (int i = 0; i < int'(KH); i++) r_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rows_in_q <= rows_in_d;
      top_q     <= top_d;
      idx_q     <= idx_d;
      fd_q      <= fd_d;
      for (int i = 0; i < int'(KH); i++) r_q[i] <= r_d[i];
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < int'(KH); i++) win[i*ROW_W +: ROW_W] = r_q[i];
  end

  assign lwb_io.ready_o      = ready;
  assign lwb_io.valid_o      = (state_q == StHold);
  assign lwb_io.window_o     = win;
  assign lwb_io.window_idx_o = idx_q;
  assign lwb_io.frame_done_o = fd_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench: dut1 uses STRIDE=1, dut2 STRIDE=2; inputs change and outputs are read on negedge.
module tb_line_window_buffer;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned W         = 24;
  localparam int unsigned K         = 6;
  localparam int unsigned H         = 6;
  localparam int unsigned KH        = 3;
  localparam int unsigned ROW_W     = W * DATA_BITS * K;
  localparam int unsigned NIB       = ROW_W / 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  line_window_buffer_if #(.DATA_BITS(DATA_BITS), .W(W), .K(K), .H(H), .KH(KH)) bus1 ();
  line_window_buffer_if #(.DATA_BITS(DATA_BITS), .W(W), .K(K), .H(H), .KH(KH)) bus2 ();

  line_window_buffer #(
    .DATA_BITS(DATA_BITS), .W(W), .K(K), .H(H), .KH(KH), .STRIDE(1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .lwb_io(bus1)
  );

  line_window_buffer #(
    .DATA_BITS(DATA_BITS), .W(W), .K(K), .H(H), .KH(KH), .STRIDE(2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .lwb_io(bus2)
  );

  // Row code: the nibble a uniform row is built from, EE for anything non-uniform.
  function automatic logic [7:0] rc(input logic [ROW_W-1:0] r);
    logic [3:0] n;
    n = r[3:0];
    if (r == {NIB{n}}) return {4'h0, n};
    return 8'hEE;
  endfunction

  function automatic logic [31:0] wc(input logic [KH*ROW_W-1:0] w);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < int'(KH); i++) c[i*8 +: 8] = rc(w[i*ROW_W +: ROW_W]);
    return c;
  endfunction

  // Expected window code, a = top (oldest) row.
  function automatic logic [31:0] w3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {8'h00, 4'h0, c, 4'h0, b, 4'h0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input int s, input string tag, input logic v, input logic rdy,
                           input logic [31:0] win, input logic chk_win, input int idx,
                           input logic fd);
    logic [31:0] gw;
    if (s == 1) begin
      check({tag, ".valid"}, {31'b0, bus1.valid_o}, {31'b0, v});
      check({tag, ".ready"}, {31'b0, bus1.ready_o}, {31'b0, rdy});
      check({tag, ".idx"}, {29'b0, bus1.window_idx_o}, idx);
      check({tag, ".fd"}, {31'b0, bus1.frame_done_o}, {31'b0, fd});
      gw = wc(bus1.window_o);
    end else begin
      check({tag, ".valid"}, {31'b0, bus2.valid_o}, {31'b0, v});
      check({tag, ".ready"}, {31'b0, bus2.ready_o}, {31'b0, rdy});
      check({tag, ".idx"}, {29'b0, bus2.window_idx_o}, idx);
      check({tag, ".fd"}, {31'b0, bus2.frame_done_o}, {31'b0, fd});
      gw = wc(bus2.window_o);
    end
    if (chk_win) check({tag, ".win"}, gw, win);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered and left on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input int s, input logic [3:0] n);
    logic [ROW_W-1:0] d;
    int t;
    d = {NIB{n}};
    t = 0;
    if (s == 1) begin
      bus1.input_data = d;
      bus1.valid_i = 1'b1;
      while (!bus1.ready_o && t < 50) begin
        @(negedge clk);
        t++;
      end
    end else begin
      bus2.input_data = d;
      bus2.valid_i = 1'b1;
      while (!bus2.ready_o && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    if (t >= 50) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus1.valid_i = 1'b0;
    bus2.valid_i = 1'b0;
  endtask

  task automatic done(input int s);
    if (s == 1) bus1.behind_conv_done = 1'b1;
    else bus2.behind_conv_done = 1'b1;
    @(negedge clk);
    bus1.behind_conv_done = 1'b0;
    bus2.behind_conv_done = 1'b0;
  endtask

  initial begin
    bus1.input_data = '0;
    bus1.valid_i = 1'b0;
    bus1.behind_conv_done = 1'b0;
    bus2.input_data = '0;
    bus2.valid_i = 1'b0;
    bus2.behind_conv_done = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    expect_st(1, "rst1", 1'b0, 1'b1, 32'h0, 1'b1, 0, 1'b0);
    expect_st(2, "rst2", 1'b0, 1'b1, 32'h0, 1'b1, 0, 1'b0);

`ifdef ZERO_PAD_EN
    // Padded frame, STRIDE=1: six windows with zero rows top and bottom
    send(1, 4'hA);
    send(1, 4'hB);
    expect_st(1, "pw0", 1'b1, 1'b0, w3(4'h0, 4'hA, 4'hB), 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      done(1);
      send(1, 4'(4'hC + i));
      expect_st(1, $sformatf("pw%0d", i + 1), 1'b1, 1'b0,
                w3(4'(4'hA + i), 4'(4'hB + i), 4'(4'hC + i)), 1'b1, i + 1, 1'b0);
    end
    done(1);
    for (int t = 0; t < 10 && !bus1.valid_o; t++) @(negedge clk);
    expect_st(1, "pw5", 1'b1, 1'b0, w3(4'hE, 4'hF, 4'h0), 1'b1, 5, 1'b0);
    done(1);
    expect_st(1, "pend", 1'b0, 1'b1, 32'h0, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("pend.fd_clear", {31'b0, bus1.frame_done_o}, 32'd0);
`else
    // STRIDE=1 full frame
    send(1, 4'hA);
    send(1, 4'hB);
    expect_st(1, "fill2", 1'b0, 1'b1, 32'h0, 1'b0, 0, 1'b0);
    send(1, 4'hC);
    expect_st(1, "w0", 1'b1, 1'b0, w3(4'hA, 4'hB, 4'hC), 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      done(1);
      expect_st(1, $sformatf("adv%0d", i + 1), 1'b0, 1'b1, 32'h0, 1'b0, i + 1, 1'b0);
      send(1, 4'(4'hD + i));
      expect_st(1, $sformatf("w%0d", i + 1), 1'b1, 1'b0,
                w3(4'(4'hB + i), 4'(4'hC + i), 4'(4'hD + i)), 1'b1, i + 1, 1'b0);
    end
    done(1);
    expect_st(1, "fend", 1'b0, 1'b1, 32'h0, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("fend.fd_clear", {31'b0, bus1.frame_done_o}, 32'd0);

    // Backpressure: D held while window (A,B,C) is in HOLD
    send(1, 4'hA);
    send(1, 4'hB);
    send(1, 4'hC);
    expect_st(1, "bp.w0", 1'b1, 1'b0, w3(4'hA, 4'hB, 4'hC), 1'b1, 0, 1'b0);
    bus1.input_data = {NIB{4'hD}};
    bus1.valid_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp.ready", {31'b0, bus1.ready_o}, 32'd0);
    end
    expect_st(1, "bp.hold", 1'b1, 1'b0, w3(4'hA, 4'hB, 4'hC), 1'b1, 0, 1'b0);
    bus1.behind_conv_done = 1'b1;
    @(negedge clk);
    bus1.behind_conv_done = 1'b0;
    expect_st(1, "bp.adv", 1'b0, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    @(negedge clk);
    bus1.valid_i = 1'b0;
    expect_st(1, "bp.w1", 1'b1, 1'b0, w3(4'hB, 4'hC, 4'hD), 1'b1, 1, 1'b0);

    // Reset mid-frame discards A,B
    do_reset();
    send(1, 4'hA);
    send(1, 4'hB);
    do_reset();
    expect_st(1, "mrst", 1'b0, 1'b1, 32'h0, 1'b1, 0, 1'b0);
    send(1, 4'hC);
    send(1, 4'hD);
    send(1, 4'hE);
    expect_st(1, "mrst.w0", 1'b1, 1'b0, w3(4'hC, 4'hD, 4'hE), 1'b1, 0, 1'b0);

    // STRIDE=2: two windows then drain of F
    send(2, 4'hA);
    send(2, 4'hB);
    send(2, 4'hC);
    expect_st(2, "s2.w0", 1'b1, 1'b0, w3(4'hA, 4'hB, 4'hC), 1'b1, 0, 1'b0);
    done(2);
    expect_st(2, "s2.adv", 1'b0, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    send(2, 4'hD);
    expect_st(2, "s2.fillD", 1'b0, 1'b1, 32'h0, 1'b0, 1, 1'b0);
    send(2, 4'hE);
    expect_st(2, "s2.w1", 1'b1, 1'b0, w3(4'hC, 4'hD, 4'hE), 1'b1, 1, 1'b0);
    done(2);
    expect_st(2, "s2.drain", 1'b0, 1'b1, 32'h0, 1'b0, 2, 1'b0);
    send(2, 4'hF);
    expect_st(2, "s2.fend", 1'b0, 1'b1, 32'h0, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("s2.fd_clear", {31'b0, bus2.frame_done_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
